// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between two icaches and two dcaches, holding locked dcache grants.
// Define ARB_STARVE_GUARD_EN to let a starved icache beat dcache traffic.
module mem_bus_arbiter #(
  parameter int WORD_W = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        iREN,
  input  logic [WORD_W-1:0] iaddr0,
  input  logic [WORD_W-1:0] iaddr1,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [WORD_W-1:0] daddr0,
  input  logic [WORD_W-1:0] daddr1,
  input  logic [WORD_W-1:0] dstore0,
  input  logic [WORD_W-1:0] dstore1,
  input  logic [1:0]        dlock,
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [2:0]        owner
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [1:0] ACCESS = 2'd2;
  state_t state, state_n;
  logic [2:0] owner_n;
  logic rr, rr_n;
  logic [1:0] dreq, istarve;
  logic is_d, core, oreq, drive, done, req_any, wd, wcore;

  function automatic logic pick(input logic [1:0] req, input logic last);
    return &req ? ~last : req[1];
  endfunction

  assign dreq = dREN | dWEN;
  assign is_d = owner[1];
  assign core = owner[0];
  assign oreq = is_d ? dreq[core] : iREN[core];
  assign drive = state == GRANT && oreq;
  assign done = drive && ramstate == ACCESS;
  assign req_any = |dreq || |iREN;
  assign wd = |dreq && !(|istarve);
  assign wcore = |istarve ? pick(istarve, rr) : pick(wd ? dreq : iREN, rr);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  for (genvar i = 0; i < 2; i++) begin : g_starve
    logic [3:0] cnt;
    logic mine;
    assign mine = owner == {2'b10, 1'(i)};
    assign istarve[i] = iREN[i] && cnt >= LIMIT;
    always_ff @(posedge CLK or negedge nRST)
      if (!nRST) cnt <= '0;
      else if (state == IDLE && req_any && !wd && wcore == 1'(i)) cnt <= '0;
      else if (iREN[i] && !mine && cnt != 4'hf) cnt <= cnt + 4'd1;
  end
`else
  assign istarve = '0;
`endif

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      rr <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr <= rr_n;
    end

  // a dropped request ends the grant silently; rr moves only on a real completion
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n = rr;
    if (state == IDLE) begin
      if (req_any) begin
        state_n = GRANT;
        owner_n = {1'b1, wd, wcore};
      end
    end else if (!oreq || (done && !(is_d && dlock[core]))) begin
      state_n = IDLE;
      owner_n[2] = 1'b0;
      rr_n = oreq ? core : rr;
    end
  end

  assign ramREN = drive && !(is_d && dWEN[core]);
  assign ramWEN = drive && is_d && dWEN[core];
  assign ramaddr = !drive ? '0 : is_d ? (core ? daddr1 : daddr0) : (core ? iaddr1 : iaddr0);
  assign ramstore = drive && is_d ? (core ? dstore1 : dstore0) : '0;
  assign iwait = ~(2'(done && !is_d) << core);
  assign dwait = ~(2'(done && is_d) << core);
  assign iload = done && !is_d ? ramload : '0;
  assign dload = done && is_d ? ramload : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and a randomized run against a request-level model.
module tb_mem_bus_arbiter;
  localparam int W = 32;
  localparam int LIMIT = 8;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] iREN, dREN, dWEN, dlock, iwait, dwait, ramstate;
  logic [W-1:0] iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1, iload, dload;
  logic [W-1:0] ramaddr, ramstore, ramload;
  logic ramREN, ramWEN;
  logic [2:0] owner;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .dREN(dREN), .dWEN(dWEN), .daddr0(daddr0), .daddr1(daddr1),
    .dstore0(dstore0), .dstore1(dstore1), .dlock(dlock),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .owner(owner)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    iREN = '0; dREN = '0; dWEN = '0; dlock = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_in();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  function automatic bit pick2(input bit a0, input bit a1, input bit last);
    return (a0 && a1) ? !last : a1;
  endfunction

  typedef struct {
    bit d; bit c; bit rd; bit wr;
    logic [W-1:0] addr, store, load;
    int busy;
    logic [2:0] e_owner; bit e_ren; bit e_wen; int e_lat;
  } vec_t;
  vec_t vt[6];
  vec_t v;

  typedef struct { bit act; int words; logic [W-1:0] addr, data; bit we, both; } rq_t;
  rq_t rq[4];
  bit mv, md, mc, mrr, drv, done;
  bit [1:0] st;
  int scnt[2];
  int lat, id, k, ic, dc;
  logic [3:0] e_wait;
  logic [2:0] s2_own [3] = '{3'b111, 3'b110, 3'b100};
  logic [3:0] s2_wait [3] = '{4'b0111, 4'b1011, 4'b1110};
  logic [W-1:0] s3_addr [2] = '{32'h80, 32'h84};
  logic [W-1:0] s3_data [2] = '{32'hCAFE0001, 32'hCAFE0002};

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h11111111, 0, 3'b100, 1'b1, 1'b0, 2};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h0, 32'h22222222, 3, 3'b101, 1'b1, 1'b0, 5};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'hAAAA0000, 32'h33333333, 1, 3'b110, 1'b1, 1'b0, 3};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h2004, 32'hBBBB1111, 32'h44444444, 2, 3'b111, 1'b0, 1'b1, 4};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h2008, 32'hCCCC2222, 32'h55555555, 0, 3'b110, 1'b0, 1'b1, 2};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h200C, 32'hDDDD3333, 32'h66666666, 4, 3'b111, 1'b1, 1'b0, 6};
    iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
    // reset state, with requests and ACCESS present to show they are ignored
    iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11; dlock = 2'b11; ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    daddr0 = 32'h77; dstore0 = 32'h88;
    #1;
    chk("rst owner", owner, 3'b000);
    chk("rst waits", {dwait, iwait}, 4'b1111);
    chk("rst strobes", {ramREN, ramWEN}, 2'b00);
    chk("rst addr", ramaddr, 0);
    chk("rst store", ramstore, 0);
    chk("rst loads", iload | dload, 0);
    tick();
    idle_in();
    nRST = 1'b1;

    for (int n = 0; n < 6; n++) begin
      v = vt[n];
      idle_in();
      if (v.d) begin
        dREN[v.c] = v.rd; dWEN[v.c] = v.wr;
        if (v.c) begin daddr1 = v.addr; dstore1 = v.store; end
        else begin daddr0 = v.addr; dstore0 = v.store; end
      end else begin
        iREN[v.c] = 1'b1;
        if (v.c) iaddr1 = v.addr; else iaddr0 = v.addr;
      end
      ramload = v.load;
      lat = 0;
      for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
        tick();
        ramstate = cyc > v.busy ? ACCESS : (cyc[0] ? BUSY : ERROR);
        #1;
        if (cyc == 1) begin
          chk($sformatf("vec%0d owner", n), owner, v.e_owner);
          chk($sformatf("vec%0d strobes", n), {ramREN, ramWEN}, {v.e_ren, v.e_wen});
          chk($sformatf("vec%0d addr", n), ramaddr, v.addr);
          chk($sformatf("vec%0d store", n), ramstore, v.d ? v.store : 32'h0);
        end
        if ((v.d ? dwait[v.c] : iwait[v.c]) == 1'b0) begin
          lat = cyc + 1;
          chk($sformatf("vec%0d load", n), v.d ? dload : iload, v.load);
        end
      end
      chk($sformatf("vec%0d latency", n), lat, v.e_lat);
      tick();
      idle_in();
      #1;
      chk($sformatf("vec%0d idle", n), owner[2], 1'b0);
    end

    // single dcache0 read at 0x40
    dREN = 2'b01; daddr0 = 32'h40; ramstate = BUSY;
    #1;
    chk("s1 c0 ren", ramREN, 1'b0);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    chk("s1 ren", ramREN, 1'b1);
    chk("s1 addr", ramaddr, 32'h40);
    chk("s1 dwait", dwait, 2'b10);
    chk("s1 dload", dload, 32'hDEADBEEF);
    tick();
    idle_in();
    #1;
    chk("s1 idle", owner[2], 1'b0);
    chk("s1 idle dwait", dwait, 2'b11);

    // three-way contention at rr=0
    dREN = 2'b11; iREN = 2'b01; daddr0 = 32'h200; daddr1 = 32'h100; iaddr0 = 32'h300;
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    for (int g = 0; g < 3; g++) begin
      tick();
      #1;
      chk($sformatf("s2 owner%0d", g), owner, s2_own[g]);
      chk($sformatf("s2 waits%0d", g), {dwait, iwait}, s2_wait[g]);
      tick();
      if (g == 0) dREN[1] = 1'b0; else if (g == 1) dREN[0] = 1'b0; else iREN[0] = 1'b0;
      #1;
      chk($sformatf("s2 gap%0d", g), owner[2], 1'b0);
    end
    idle_in();

    // icache1 abandons its request before ACCESS; rr must stay 0
    iREN = 2'b10; iaddr1 = 32'h500; ramstate = BUSY;
    tick();
    #1;
    chk("s4 owner", owner, 3'b101);
    chk("s4 ren", ramREN, 1'b1);
    tick();
    iREN = 2'b00;
    #1;
    chk("s4 drop ren", ramREN, 1'b0);
    chk("s4 drop iwait", iwait, 2'b11);
    tick();
    dREN = 2'b11; ramstate = ACCESS;
    #1;
    chk("s4 idle", owner[2], 1'b0);
    tick();
    #1;
    chk("s4 rr kept", owner, 3'b111);
    tick();
    idle_in();
    #1;
    chk("s4 end", owner[2], 1'b0);

    // locked two-word write-back by dcache1, two BUSY cycles per word
    dWEN = 2'b10; dlock = 2'b10; daddr1 = s3_addr[0]; dstore1 = s3_data[0]; ramstate = BUSY;
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 3; b++) begin
        tick();
        if (w == 1 && b == 0) begin daddr1 = s3_addr[1]; dstore1 = s3_data[1]; dlock = 2'b00; end
        ramstate = b == 2 ? ACCESS : BUSY;
        #1;
        chk($sformatf("s3 owner w%0d b%0d", w, b), owner, 3'b111);
        chk($sformatf("s3 wen w%0d b%0d", w, b), ramWEN, 1'b1);
        chk($sformatf("s3 addr w%0d b%0d", w, b), ramaddr, s3_addr[w]);
        chk($sformatf("s3 store w%0d b%0d", w, b), ramstore, s3_data[w]);
        chk($sformatf("s3 dwait w%0d b%0d", w, b), dwait, b == 2 ? 2'b01 : 2'b11);
      end
    tick();
    idle_in();
    #1;
    chk("s3 idle", owner[2], 1'b0);

    // asynchronous reset in the middle of a write grant
    dWEN = 2'b01; daddr0 = 32'h600; dstore0 = 32'h12345678; ramstate = BUSY;
    tick();
    #1;
    chk("s5 pre wen", ramWEN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("s5 wen", ramWEN, 1'b0);
    chk("s5 waits", {dwait, iwait}, 4'b1111);
    chk("s5 owner", owner, 3'b000);
    chk("s5 addr", ramaddr, 0);
    tick();
    nRST = 1'b1;
    #1;
    chk("s5 release", owner, 3'b000);
    tick();
    ramstate = ACCESS;
    #1;
    chk("s5 regrant", owner, 3'b110);
    chk("s5 regrant wen", ramWEN, 1'b1);
    chk("s5 regrant dwait", dwait, 2'b10);
    tick();
    idle_in();

    // continuous dcache0 traffic with icache0 waiting
    do_reset();
    dREN = 2'b01; iREN = 2'b01; ramstate = ACCESS;
    ic = 0; dc = 0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      #1;
      if (iwait[0] == 1'b0) ic++;
      if (dwait[0] == 1'b0) dc++;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve icache grants", ic, 4);
    chk("starve dcache grants", dc, 16);
`else
    chk("starve icache grants", ic, 0);
    chk("starve dcache grants", dc, 20);
`endif

    // randomized traffic against a request-level model
    do_reset();
    mv = 0; md = 0; mc = 0; mrr = 0; scnt[0] = 0; scnt[1] = 0;
    for (int r = 0; r < 4; r++) rq[r] = '{1'b0, 0, '0, '0, 1'b0, 1'b0};
    for (int t = 0; t < 1500; t++) begin
      for (int r = 0; r < 4; r++)
        if (!rq[r].act && $urandom_range(2) == 0) begin
          rq[r].act = 1'b1;
          rq[r].words = r >= 2 ? int'($urandom_range(1, 3)) : 1;
          rq[r].addr = $urandom & ~32'h3;
          rq[r].data = $urandom;
          rq[r].we = r >= 2 && $urandom_range(1) == 1;
          rq[r].both = $urandom_range(1) == 1;
        end
      iREN = {rq[1].act, rq[0].act};
      for (int c = 0; c < 2; c++) begin
        dWEN[c] = rq[2+c].act && rq[2+c].we;
        dREN[c] = rq[2+c].act && (!rq[2+c].we || rq[2+c].both);
        dlock[c] = rq[2+c].act && rq[2+c].words > 1;
      end
      iaddr0 = rq[0].addr; iaddr1 = rq[1].addr; daddr0 = rq[2].addr; daddr1 = rq[3].addr;
      dstore0 = rq[2].data; dstore1 = rq[3].data;
      k = $urandom_range(4);
      ramstate = k == 2 ? ERROR : k >= 3 ? ACCESS : 2'(k);
      ramload = $urandom;
      #1;
      id = md ? 2 + int'(mc) : int'(mc);
      drv = mv && rq[id].act;
      done = drv && ramstate == ACCESS;
      e_wait = 4'b1111;
      if (done) e_wait[id] = 1'b0;
      chk("rnd owner", owner, {mv, md, mc});
      chk("rnd strobes", {ramREN, ramWEN}, {drv && !(md && rq[id].we), drv && md && rq[id].we});
      chk("rnd addr", ramaddr, drv ? rq[id].addr : 32'h0);
      chk("rnd store", ramstore, drv && md ? rq[id].data : 32'h0);
      chk("rnd waits", {dwait, iwait}, e_wait);
      chk("rnd iload", iload, done && !md ? ramload : 32'h0);
      chk("rnd dload", dload, done && md ? ramload : 32'h0);
      st = '0;
`ifdef ARB_STARVE_GUARD_EN
      for (int i = 0; i < 2; i++) begin
        st[i] = rq[i].act && scnt[i] >= LIMIT;
        if (rq[i].act && !(mv && !md && int'(mc) == i)) scnt[i] = scnt[i] == 15 ? 15 : scnt[i] + 1;
      end
`endif
      if (!mv) begin
        if (|st) begin mv = 1; md = 0; mc = pick2(st[0], st[1], mrr); end
        else if (rq[2].act || rq[3].act) begin mv = 1; md = 1; mc = pick2(rq[2].act, rq[3].act, mrr); end
        else if (rq[0].act || rq[1].act) begin mv = 1; md = 0; mc = pick2(rq[0].act, rq[1].act, mrr); end
        if (mv && !md) scnt[mc] = 0;
      end else if (done) begin
        rq[id].words = rq[id].words - 1;
        if (rq[id].words > 0) begin
          rq[id].addr = rq[id].addr + 32'd4;
          rq[id].data = $urandom;
        end else begin
          rq[id].act = 1'b0;
          mv = 0;
          mrr = mc;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
